// File: rtl/reorder_pkg.sv
// Shared constants for the planar-to-interleaved reorder sequencer.
// Holds the state encoding, plane/word selects and the read-latency limit.
package reorder_pkg;

    localparam logic [3:0] S_IDLE  = 4'd0;
    localparam logic [3:0] S_CLR   = 4'd1;
    localparam logic [3:0] S_CHECK = 4'd2;
    localparam logic [3:0] S_REQ_R = 4'd3;
    localparam logic [3:0] S_LD_R  = 4'd4;
    localparam logic [3:0] S_REQ_G = 4'd5;
    localparam logic [3:0] S_LD_G  = 4'd6;
    localparam logic [3:0] S_REQ_B = 4'd7;
    localparam logic [3:0] S_LD_B  = 4'd8;
    localparam logic [3:0] S_WR0   = 4'd9;
    localparam logic [3:0] S_WR1   = 4'd10;
    localparam logic [3:0] S_WR2   = 4'd11;
    localparam logic [3:0] S_DONE  = 4'd12;

    localparam logic [1:0] PLANE_R = 2'd0;
    localparam logic [1:0] PLANE_G = 2'd1;
    localparam logic [1:0] PLANE_B = 2'd2;

    localparam logic [1:0] WSEL_0 = 2'd0;
    localparam logic [1:0] WSEL_1 = 2'd1;
    localparam logic [1:0] WSEL_2 = 2'd2;

    localparam int RD_LAT_MAX = 4;

    function automatic logic is_req(input logic [3:0] s);
        return (s == S_REQ_R) || (s == S_REQ_G) || (s == S_REQ_B);
    endfunction

endpackage

// File: rtl/lat_wait_counter.sv
// Small down-counter that times how long a memory read request is held.
// Loads a start value, counts down to zero and then holds there.
module lat_wait_counter (
    input  logic       clk,
    input  logic       rst,
    input  logic       load,
    input  logic       dec,
    input  logic [2:0] load_value,
    output logic       zero
);

    logic [2:0] count;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count <= 3'd0;
        end else if (load) begin
            count <= load_value;
        end else if (dec && (count != 3'd0)) begin
            count <= count - 3'd1;
        end
    end

    assign zero = (count == 3'd0);

endmodule

// File: rtl/reorder_controller.sv
// Sequencer for reorder_datapath: reads one word per R/G/B plane, then writes
// three packed words, repeating until the datapath read counter is exhausted.
module reorder_controller
    import reorder_pkg::*;
#(
    parameter int RD_LAT = 1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic       rd_done,
    input  logic       wr_done,
    output logic       clr,
    output logic [1:0] selAdd,
    output logic       ldenR,
    output logic       ldenG,
    output logic       ldenB,
    output logic       count_en_rd,
    output logic [1:0] selWdata,
    output logic       count_en_wr,
    output logic       mem_rd,
    output logic       mem_wr,
    output logic       busy,
    output logic       done,
    output logic       err
);

    localparam logic [2:0] WAIT_LOAD = 3'(RD_LAT - 1);

    logic [3:0] state;
    logic [3:0] state_next;
    logic       in_req;
    logic       wait_zero;

    assign in_req = is_req(state);

    // Reloaded in every non-request state so each REQ_x starts a fresh dwell.
    lat_wait_counter u_wait (
        .clk        (clk),
        .rst        (rst),
        .load       (!in_req),
        .dec        (in_req),
        .load_value (WAIT_LOAD),
        .zero       (wait_zero)
    );

    always_comb begin
        state_next = state;
        case (state)
            S_IDLE:  if (start) state_next = S_CLR;
            S_CLR:   state_next = S_CHECK;
            S_CHECK: state_next = rd_done ? S_DONE : S_REQ_R;
            S_REQ_R: if (wait_zero) state_next = S_LD_R;
            S_LD_R:  state_next = S_REQ_G;
            S_REQ_G: if (wait_zero) state_next = S_LD_G;
            S_LD_G:  state_next = S_REQ_B;
            S_REQ_B: if (wait_zero) state_next = S_LD_B;
            S_LD_B:  state_next = S_WR0;
            S_WR0:   state_next = S_WR1;
            S_WR1:   state_next = S_WR2;
            S_WR2:   state_next = S_CHECK;
            S_DONE:  state_next = S_IDLE;
            default: state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Reports whether the write side finished exactly when the read side did.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            err <= 1'b0;
        end else if ((state == S_IDLE) && start) begin
            err <= 1'b0;
        end else if ((state == S_CHECK) && rd_done) begin
            err <= ~wr_done;
        end
    end

    always_comb begin
        clr         = 1'b0;
        selAdd      = PLANE_R;
        ldenR       = 1'b0;
        ldenG       = 1'b0;
        ldenB       = 1'b0;
        count_en_rd = 1'b0;
        selWdata    = WSEL_0;
        count_en_wr = 1'b0;
        mem_rd      = 1'b0;
        mem_wr      = 1'b0;
        busy        = (state != S_IDLE) && (state != S_DONE);
        done        = (state == S_DONE);
        case (state)
            S_CLR:   clr = 1'b1;
            S_REQ_R: mem_rd = 1'b1;
            S_LD_R:  ldenR = 1'b1;
            S_REQ_G: begin
                selAdd = PLANE_G;
                mem_rd = 1'b1;
            end
            S_LD_G: begin
                selAdd = PLANE_G;
                ldenG  = 1'b1;
            end
            S_REQ_B: begin
                selAdd = PLANE_B;
                mem_rd = 1'b1;
            end
            S_LD_B: begin
                selAdd      = PLANE_B;
                ldenB       = 1'b1;
                count_en_rd = 1'b1;
            end
            S_WR0: begin
                mem_wr      = 1'b1;
                count_en_wr = 1'b1;
            end
            S_WR1: begin
                selWdata    = WSEL_1;
                mem_wr      = 1'b1;
                count_en_wr = 1'b1;
            end
            S_WR2: begin
                selWdata    = WSEL_2;
                mem_wr      = 1'b1;
                count_en_wr = 1'b1;
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_reorder_controller.sv
// Self-checking bench for reorder_controller at RD_LAT=1 and RD_LAT=3, each
// driven by a small counter model of the datapath's rd_done/wr_done.
module tb_reorder_controller;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst;
    logic start1, start3;
    int   rlimit, wlimit;

    logic       rd_done1, wr_done1, clr1, ldenR1, ldenG1, ldenB1, cer1, cew1;
    logic       mem_rd1, mem_wr1, busy1, done1, err1;
    logic [1:0] selAdd1, selWdata1;
    logic       rd_done3, wr_done3, clr3, ldenR3, ldenG3, ldenB3, cer3, cew3;
    logic       mem_rd3, mem_wr3, busy3, done3, err3;
    logic [1:0] selAdd3, selWdata3;

    reorder_controller #(.RD_LAT(1)) dut1 (
        .clk(clk), .rst(rst), .start(start1), .rd_done(rd_done1), .wr_done(wr_done1),
        .clr(clr1), .selAdd(selAdd1), .ldenR(ldenR1), .ldenG(ldenG1), .ldenB(ldenB1),
        .count_en_rd(cer1), .selWdata(selWdata1), .count_en_wr(cew1),
        .mem_rd(mem_rd1), .mem_wr(mem_wr1), .busy(busy1), .done(done1), .err(err1)
    );

    reorder_controller #(.RD_LAT(3)) dut3 (
        .clk(clk), .rst(rst), .start(start3), .rd_done(rd_done3), .wr_done(wr_done3),
        .clr(clr3), .selAdd(selAdd3), .ldenR(ldenR3), .ldenG(ldenG3), .ldenB(ldenB3),
        .count_en_rd(cer3), .selWdata(selWdata3), .count_en_wr(cew3),
        .mem_rd(mem_rd3), .mem_wr(mem_wr3), .busy(busy3), .done(done3), .err(err3)
    );

    // Datapath stand-in: counters cleared by clr (or rst), done flags by equality.
    int rcnt1, wcnt1, rcnt3, wcnt3;
    always_ff @(posedge clk or posedge rst) begin
        if (rst || clr1) begin
            rcnt1 <= 0;
            wcnt1 <= 0;
        end else begin
            if (cer1) rcnt1 <= rcnt1 + 1;
            if (cew1) wcnt1 <= wcnt1 + 1;
        end
    end
    always_ff @(posedge clk or posedge rst) begin
        if (rst || clr3) begin
            rcnt3 <= 0;
            wcnt3 <= 0;
        end else begin
            if (cer3) rcnt3 <= rcnt3 + 1;
            if (cew3) wcnt3 <= wcnt3 + 1;
        end
    end
    assign rd_done1 = (rcnt1 == rlimit);
    assign wr_done1 = (wcnt1 == wlimit);
    assign rd_done3 = (rcnt3 == rlimit);
    assign wr_done3 = (wcnt3 == wlimit);

    logic [13:0] obs1, obs3;
    assign obs1 = {clr1, selAdd1, ldenR1, ldenG1, ldenB1, cer1, selWdata1, cew1,
                   mem_rd1, mem_wr1, busy1, done1};
    assign obs3 = {clr3, selAdd3, ldenR3, ldenG3, ldenB3, cer3, selWdata3, cew3,
                   mem_rd3, mem_wr3, busy3, done3};

    int tests_run = 0;
    int tests_failed = 0;
    int exp_q[$];

    function automatic int get_obs(input int sel);
        return (sel != 0) ? int'(obs3) : int'(obs1);
    endfunction

    function automatic int get_err(input int sel);
        return (sel != 0) ? int'(err3) : int'(err1);
    endfunction

    function automatic int pack_out(input bit c, input int sel_add, input int lden, input bit cer,
                                    input int selw, input bit cew, input bit rd, input bit wr,
                                    input bit bsy, input bit dn);
        logic [13:0] v;
        v = {c, 2'(sel_add), 3'(lden), cer, 2'(selw), cew, rd, wr, bsy, dn};
        return int'(v);
    endfunction

    // Expected per-cycle outputs from CLR to the first IDLE after DONE.
    function automatic void build_trace(input int groups, input int lat);
        exp_q.delete();
        exp_q.push_back(pack_out(1, 0, 0, 0, 0, 0, 0, 0, 1, 0));
        for (int g = 0; g < groups; g++) begin
            exp_q.push_back(pack_out(0, 0, 0, 0, 0, 0, 0, 0, 1, 0));
            for (int p = 0; p < 3; p++) begin
                for (int w = 0; w < lat; w++)
                    exp_q.push_back(pack_out(0, p, 0, 0, 0, 0, 1, 0, 1, 0));
                exp_q.push_back(pack_out(0, p, 4 >> p, p == 2, 0, 0, 0, 0, 1, 0));
            end
            for (int k = 0; k < 3; k++)
                exp_q.push_back(pack_out(0, 0, 0, 0, k, 1, 0, 1, 1, 0));
        end
        exp_q.push_back(pack_out(0, 0, 0, 0, 0, 0, 0, 0, 1, 0));
        exp_q.push_back(pack_out(0, 0, 0, 0, 0, 0, 0, 0, 0, 1));
        exp_q.push_back(0);
    endfunction

    task automatic applyStimulus(input int sel, input logic s);
        start1 = (sel == 0) ? s : 1'b0;
        start3 = (sel != 0) ? s : 1'b0;
    endtask

    task automatic checkOutput(input string name, input int actual, input int expected);
        tests_run++;
        if (actual !== expected) begin
            tests_failed++;
            $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
        end
    endtask

    // Runs one start..done transaction; abort_cycle>0 asserts rst in that cycle instead.
    task automatic run_case(input int sel, input int rl, input int wl, input int exp_err,
                            input int exp_done, input bit rand_start, input int abort_cycle);
        int done_seen;
        int cyc;
        build_trace(rl, (sel != 0) ? 3 : 1);
        @(negedge clk);
        rlimit = rl;
        wlimit = wl;
        applyStimulus(sel, 1'b1);
        done_seen = -1;
        for (int i = 0; i < exp_q.size(); i++) begin
            @(negedge clk);
            cyc = i + 1;
            if (cyc == abort_cycle) begin
                applyStimulus(sel, 1'b0);
                rst = 1'b1;
                #1;
                checkOutput("reset_mid_outputs", get_obs(sel), 0);
                checkOutput("reset_mid_err", get_err(sel), 0);
                checkOutput("reset_mid_no_done", done_seen, -1);
                @(negedge clk);
                rst = 1'b0;
                return;
            end
            checkOutput($sformatf("sel%0d_r%0d_cycle%0d", sel, rl, cyc), get_obs(sel), exp_q[i]);
            if (cyc == 1) checkOutput("err_cleared_by_start", get_err(sel), 0);
            if ((get_obs(sel) & 1) != 0 && done_seen < 0) done_seen = cyc;
            applyStimulus(sel, (rand_start && exp_q[i] != 0) ? ($urandom_range(0, 2) == 0) : 1'b0);
        end
        checkOutput($sformatf("done_cycle_sel%0d_r%0d", sel, rl), done_seen, exp_done);
        checkOutput($sformatf("err_sel%0d_r%0d_w%0d", sel, rl, wl), get_err(sel), exp_err);
    endtask

    typedef struct {
        int sel;
        int rl;
        int wl;
        int err;
        int done_cyc;
        bit rand_start;
    } vec_t;

    initial begin
        vec_t vecs[8];
        int sel, rl, wl, lat;

        // sel: 0 = RD_LAT 1 instance, 1 = RD_LAT 3 instance.
        vecs[0] = '{0, 4, 12, 0, 43, 1'b0};
        vecs[1] = '{0, 0, 0, 0, 3, 1'b0};
        vecs[2] = '{0, 1, 5, 1, 13, 1'b0};
        vecs[3] = '{0, 1, 3, 0, 13, 1'b0};
        vecs[4] = '{1, 1, 3, 0, 19, 1'b0};
        vecs[5] = '{0, 2, 6, 0, 23, 1'b1};
        vecs[6] = '{1, 0, 0, 0, 3, 1'b1};
        vecs[7] = '{0, 0, 4, 1, 3, 1'b0};

        rst = 1'b1;
        start1 = 1'b0;
        start3 = 1'b0;
        rlimit = 0;
        wlimit = 0;
        repeat (2) @(negedge clk);
        checkOutput("reset_outputs_lat1", get_obs(0), 0);
        checkOutput("reset_err_lat1", get_err(0), 0);
        checkOutput("reset_outputs_lat3", get_obs(1), 0);
        checkOutput("reset_err_lat3", get_err(1), 0);
        rst = 1'b0;

        foreach (vecs[i])
            run_case(vecs[i].sel, vecs[i].rl, vecs[i].wl, vecs[i].err,
                     vecs[i].done_cyc, vecs[i].rand_start, 0);

        // Reset during WR1 of the second group, then a clean replay.
        run_case(0, 4, 12, 0, 43, 1'b0, 20);
        run_case(0, 4, 12, 0, 43, 1'b0, 0);

        for (int n = 0; n < 12; n++) begin
            sel = int'($urandom_range(0, 1));
            rl  = int'($urandom_range(0, 5));
            wl  = ($urandom_range(0, 1) != 0) ? 3 * rl : int'($urandom_range(0, 17));
            lat = (sel != 0) ? 3 : 1;
            run_case(sel, rl, wl, (wl != 3 * rl) ? 1 : 0,
                     3 + rl * (3 * (lat + 1) + 4), 1'b1, 0);
        end

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
